// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : int_ctrl
// Brief   : Single-source edge-triggered interrupt controller driving the CPU
//           entry sequence (request, PC save/flush, vector load, service).
// Rev     : 1.0  initial release
// ============================================================================
module int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,      // legal range 2..4
  parameter logic [7:0]  VEC_PTR     = 8'h01
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       int_sig,
  input  logic       int_en,
  input  logic       instr_done,
  input  logic       int_ack,
  input  logic       rti,
  output logic       int_req,
  output logic       pc_save,
  output logic       flush,
  output logic       vec_sel,
  output logic [7:0] vec_ptr,
  output logic       in_service,
  output logic       pending,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SAVE    = 3'd2,
    S_VECTOR  = 3'd3,
    S_SERVICE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_pending;
  logic                   r_overrun;
  logic                   w_edge;
  logic                   w_ack_clr;
  logic                   w_rti_take;

  // r_fill tracks which stages hold a genuine post-reset sample, so a line
  // already high when reset is released is never mistaken for a rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], int_sig};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist & r_fill[SYNC_STAGES];
  assign w_ack_clr  = (r_state == S_REQ) && int_ack;
  assign w_rti_take = (r_state == S_SERVICE) && rti;

  // An edge arriving with the clearing ack becomes the next request, not a loss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_ack_clr) begin
        r_pending <= w_edge;
      end else if (w_edge) begin
        r_pending <= 1'b1;
      end
      if (w_rti_take) begin
        r_overrun <= 1'b0;
      end
      if (w_edge && r_pending && !w_ack_clr) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    int_req    = 1'b0;
    pc_save    = 1'b0;
    flush      = 1'b0;
    vec_sel    = 1'b0;
    in_service = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pending && int_en && instr_done) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          w_next = S_SAVE;
        end else if (!int_en) begin
          w_next = S_IDLE;
        end
      end
      S_SAVE: begin
        pc_save = 1'b1;
        flush   = 1'b1;
        w_next  = S_VECTOR;
      end
      S_VECTOR: begin
        vec_sel = 1'b1;
        w_next  = S_SERVICE;
      end
      S_SERVICE: begin
        in_service = 1'b1;
        if (rti) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign pending = r_pending;
  assign overrun = r_overrun;
  assign vec_ptr = VEC_PTR;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_int_ctrl
// Brief   : Scoreboard bench for int_ctrl: directed scenarios plus random
//           traffic checked against a cycle-level behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

  localparam int         S  = 2;
  localparam logic [7:0] VP = 8'h01;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       int_sig = 1'b0;
  logic       int_en = 1'b0;
  logic       instr_done = 1'b0;
  logic       int_ack = 1'b0;
  logic       rti = 1'b0;
  logic       int_req, pc_save, flush, vec_sel, in_service, pending, overrun;
  logic [7:0] vec_ptr;

  always #5 clk = ~clk;

  int_ctrl #(.SYNC_STAGES(S), .VEC_PTR(VP)) dut (
    .clk(clk), .rstn(rstn), .int_sig(int_sig), .int_en(int_en),
    .instr_done(instr_done), .int_ack(int_ack), .rti(rti),
    .int_req(int_req), .pc_save(pc_save), .flush(flush), .vec_sel(vec_sel),
    .vec_ptr(vec_ptr), .in_service(in_service), .pending(pending),
    .overrun(overrun)
  );

  // Reference model: where the CPU handshake currently stands, plus the
  // latched request and lost-edge flag, and the int_sig samples since reset.
  typedef enum int {M_IDLE, M_REQ, M_SAVE, M_VEC, M_SRV} mph_t;
  mph_t        m_ph;
  bit          m_pend;
  bit          m_ovr;
  bit          smp[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [14:0] expect_vec();
    return {m_ph == M_REQ, m_ph == M_SAVE, m_ph == M_SAVE, m_ph == M_VEC,
            m_ph == M_SRV, m_pend, m_ovr, VP};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = M_IDLE;
      m_pend = 1'b0;
      m_ovr = 1'b0;
      smp.delete();
      exp_q.delete();
      exp_q.push_back(expect_vec());
    end else begin
      bit   edge_seen;
      bit   acked;
      mph_t nx;
      // A rising edge sampled at clock t-S (with a real low sample before it)
      // becomes visible to the controller at clock t.
      smp.push_back(int_sig);
      if (smp.size() > S + 2) void'(smp.pop_front());
      edge_seen = (smp.size() == S + 2) && smp[1] && !smp[0];
      acked = (m_ph == M_REQ) && int_ack;
      nx = m_ph;
      case (m_ph)
        M_IDLE: if (m_pend && int_en && instr_done) nx = M_REQ;
        M_REQ:  if (int_ack) nx = M_SAVE; else if (!int_en) nx = M_IDLE;
        M_SAVE: nx = M_VEC;
        M_VEC:  nx = M_SRV;
        M_SRV:  if (rti) nx = M_IDLE;
        default: nx = M_IDLE;
      endcase
      if (m_ph == M_SRV && rti) m_ovr = 1'b0;
      if (edge_seen && m_pend && !acked) m_ovr = 1'b1;
      m_pend = acked ? edge_seen : (m_pend | edge_seen);
      m_ph = nx;
      exp_q.push_back(expect_vec());
    end
  end

  always @(negedge clk) begin
    logic [14:0] act;
    logic [14:0] expv;
    act = {int_req, pc_save, flush, vec_sel, in_service, pending, overrun, vec_ptr};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t act=%b", $time, act);
    end else begin
      expv = exp_q.pop_front();
      if (act !== expv) begin
        errors++;
        $display("FAIL outputs t=%0t act=%b exp=%b (req,save,flush,vec,srv,pend,ovr,ptr)",
                 $time, act, expv);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic step(input bit s, input bit en, input bit d, input bit a, input bit r);
    @(posedge clk);
    #2;
    int_sig = s;
    int_en = en;
    instr_done = d;
    int_ack = a;
    rti = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit s;
    repeat (3) step(0, 0, 0, 0, 0);
    rstn = 1'b1;

    // basic request / ack / service / rti
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0);

    // masked, then unmasked
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    check("masked_pending", {31'd0, pending}, 32'd1);
    check("masked_no_req", {31'd0, int_req}, 32'd0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);

    // overrun: two rising edges six cycles apart, no instr_done
    repeat (2) step(1, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    check("overrun_set", {30'd0, pending, overrun}, 32'd3);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("overrun_cleared_by_rti", {31'd0, overrun}, 32'd0);

    // nesting: edge during service waits for rti
    repeat (3) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (2) step(1, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    check("nest_no_req", {29'd0, int_req, in_service, pending}, 32'd3);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);

    // simultaneous edge and int_ack
    repeat (3) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (S) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    check("simul_in_save", {29'd0, pc_save, pending, overrun}, 32'd6);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);

    // asynchronous reset in the middle of SAVE, int_sig held high through it
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    check("pre_reset_save", {31'd0, pc_save}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          {17'd0, int_req, pc_save, flush, vec_sel, in_service, pending, overrun, vec_ptr},
          {24'd0, VP});
    repeat (2) step(1, 0, 0, 0, 0);
    rstn = 1'b1;
    repeat (8) step(1, 1, 1, 0, 0);
    check("held_high_no_edge", {30'd0, pending, pc_save}, 32'd0);
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    check("edge_after_reset", {31'd0, pending}, 32'd1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);

    // random traffic
    s = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) s = ~s;
      step(s, $urandom_range(7) != 0, $urandom_range(3) == 0,
           $urandom_range(2) == 0, $urandom_range(5) == 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
